// File: rtl/dht11_reader.sv
// dht11_reader: polls a DHT11 over one open-drain pin, decodes the 40-bit frame and checks its sum.
// Results are registered one cycle after CHECK. There is no backpressure. DHT_RETRY_EN enables 2 ms retries after errors.
module dht11_reader #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int POLL_MS       = 1000,
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 200,
  parameter int BIT_THRESH_US = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  inout  wire        dht11_data,
  output logic [7:0] tem,
  output logic [7:0] hum,
  output logic       data_valid,
  output logic       cks_err,
  output logic       timeout_err,
  output logic       busy
);

  localparam int DIV     = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
  localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_MAX = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int MW      = $clog2(POLL_MS + 3);

  typedef enum logic [2:0] {
    S_IDLE, S_START_LOW, S_WAIT_ACK, S_RESP_LOW,
    S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_CHECK
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [PW-1:0] pres_q, pres_d;
  logic [9:0]    us_q, us_d;
  logic [MW-1:0] ms_q, ms_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    bit_idx_q, bit_idx_d;
  logic [39:0]   frame_q, frame_d;
  logic [7:0]    tem_q, tem_d, hum_q, hum_d;
  logic          drive_q, drive_d, busy_q, busy_d;
  logic          dv_q, dv_d, ce_q, ce_d, te_q, te_d;

  logic          tick, rise, fall;
  logic [CW:0]   hi_time;
  logic [9:0]    sum;
  logic [MW-1:0] wait_ms;

`ifdef DHT_RETRY_EN
  logic [1:0] retry_q, retry_d;
  logic       short_q, short_d;
  assign wait_ms = short_q ? MW'(2) : MW'(POLL_MS);
`else
  assign wait_ms = MW'(POLL_MS);
`endif

  assign tick    = (pres_q == PW'(DIV - 1));
  assign rise    = sync2_q & ~prev_q;
  assign fall    = ~sync2_q & prev_q;
  // Includes the current tick so a high of N us measures exactly N.
  assign hi_time = {1'b0, cnt_q} + {{CW{1'b0}}, tick};
  assign sum     = {2'b00, frame_q[39:32]} + {2'b00, frame_q[31:24]}
                 + {2'b00, frame_q[23:16]} + {2'b00, frame_q[15:8]};

  always_comb begin
    state_d   = state_q;
    sync1_d   = dht11_data;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    pres_d    = tick ? '0 : pres_q + 1'b1;
    us_d      = us_q;
    ms_d      = ms_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    tem_d     = tem_q;
    hum_d     = hum_q;
    dv_d      = 1'b0;
    ce_d      = 1'b0;
    te_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          if (ms_q == wait_ms) begin
            state_d = S_START_LOW;
          end else if (tick) begin
            if (us_q == 10'd999) begin
              us_d = '0;
              ms_d = ms_q + 1'b1;
            end else begin
              us_d = us_q + 1'b1;
            end
          end
        end else begin
          us_d = '0;
          ms_d = '0;
        end
      end
      S_START_LOW: begin
        bit_idx_d = '0;
        if (tick && cnt_q == CW'(START_LOW_US - 1)) state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK:  if (fall) state_d = S_RESP_LOW;
      S_RESP_LOW:  if (rise) state_d = S_RESP_HIGH;
      S_RESP_HIGH: if (fall) state_d = S_BIT_LOW;
      S_BIT_LOW:   if (rise) state_d = S_BIT_HIGH;
      S_BIT_HIGH: begin
        if (fall) begin
          frame_d = {frame_q[38:0], (hi_time > (CW+1)'(BIT_THRESH_US))};
          if (bit_idx_q == 6'd39) begin
            state_d = S_CHECK;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            state_d   = S_BIT_LOW;
          end
        end
      end
      S_CHECK: begin
        if (sum[7:0] == frame_q[7:0]) begin
          tem_d = frame_q[23:16];
          hum_d = frame_q[39:32];
          dv_d  = 1'b1;
        end else begin
          ce_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q inside {S_WAIT_ACK, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH})
        && state_d == state_q && tick && cnt_q == CW'(TIMEOUT_US - 1)) begin
      state_d = S_IDLE;
      te_d    = 1'b1;
    end

    if (state_d != S_IDLE) begin
      us_d = '0;
      ms_d = '0;
    end
    if (state_d != state_q)                cnt_d = '0;
    else if (tick && state_q != S_IDLE)    cnt_d = cnt_q + 1'b1;

    drive_d = (state_d == S_START_LOW);
    busy_d  = (state_d != S_IDLE);

`ifdef DHT_RETRY_EN
    retry_d = retry_q;
    short_d = short_q;
    if (dv_d) begin
      retry_d = '0;
      short_d = 1'b0;
    end else if (ce_d || te_d) begin
      if (retry_q != 2'd3) begin
        retry_d = retry_q + 1'b1;
        short_d = 1'b1;
      end else begin
        short_d = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      pres_q    <= '0;
      us_q      <= '0;
      ms_q      <= '0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      frame_q   <= '0;
      tem_q     <= '0;
      hum_q     <= '0;
      drive_q   <= 1'b0;
      busy_q    <= 1'b0;
      dv_q      <= 1'b0;
      ce_q      <= 1'b0;
      te_q      <= 1'b0;
`ifdef DHT_RETRY_EN
      retry_q   <= '0;
      short_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      pres_q    <= pres_d;
      us_q      <= us_d;
      ms_q      <= ms_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      frame_q   <= frame_d;
      tem_q     <= tem_d;
      hum_q     <= hum_d;
      drive_q   <= drive_d;
      busy_q    <= busy_d;
      dv_q      <= dv_d;
      ce_q      <= ce_d;
      te_q      <= te_d;
`ifdef DHT_RETRY_EN
      retry_q   <= retry_d;
      short_q   <= short_d;
`endif
    end
  end

  assign dht11_data  = drive_q ? 1'b0 : 1'bz;
  assign tem         = tem_q;
  assign hum         = hum_q;
  assign data_valid  = dv_q;
  assign cks_err     = ce_q;
  assign timeout_err = te_q;
  assign busy        = busy_q;

endmodule

// File: doc/dht11_reader.md
Name: dht11_reader

Overview:
- Open-drain DHT11 one-wire master, directly upstream of the temperature/humidity consumers (UART telemetry, danger detection, set-temperature control).
- Periodically issues a start pulse, decodes the 40-bit sensor frame and verifies the checksum.
- Publishes validated integer temperature and humidity bytes with a one-cycle valid strobe.
- Owns the dht11_data pad.

Parameters:
- CLK_HZ, 100_000_000: system clock frequency; a 1 us tick is derived from it (CLK_HZ/1_000_000 cycles per tick).
- POLL_MS, 1000: idle interval between measurements, in ms.
- START_LOW_US, 18000: host start-pulse low time.
- TIMEOUT_US, 200: maximum dwell in any wait-for-edge state.
- BIT_THRESH_US, 50: high-time threshold separating bit 0 from bit 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  allows new measurements to start.
- dht11_data  inout  1  sensor line; driven 0 when pulling low, else Z (external pull-up).
- tem  out  8  last valid temperature integer byte.
- hum  out  8  last valid humidity integer byte.
- data_valid  out  1  one-cycle pulse on successful frame.
- cks_err  out  1  one-cycle pulse on checksum mismatch.
- timeout_err  out  1  one-cycle pulse on protocol timeout.
- busy  out  1  high from START_LOW entry until return to IDLE.

Behaviour:
- Reset (reset=0, async): line released (Z); tem=0, hum=0; all pulses 0; busy=0; FSM=IDLE; all counters 0.
- Input path: dht11_data passes through a 2-flop synchronizer. All edge detection uses the synchronized value, so edges are seen 2–3 clk late.
- us tick: free-running prescaler, 1-cycle pulse every CLK_HZ/1e6 clk. The ms counter counts 1000 ticks.
- IDLE:
  - Line released.
  - With enable=1, count POLL_MS ms, then go to START_LOW. With enable=0, the counter holds at 0.
  - The first measurement after reset occurs POLL_MS after reset release.
- START_LOW: drive 0 for START_LOW_US ticks, then release and go to WAIT_ACK.
- Wait-for-edge states (all released):
  - WAIT_ACK: line falls → RESP_LOW.
  - RESP_LOW: rises → RESP_HIGH.
  - RESP_HIGH: falls → BIT_LOW.
  - BIT_LOW: rises → BIT_HIGH; clear the high-time counter.
  - BIT_HIGH: count ticks. On falling edge, shift in bit (1 if count > BIT_THRESH_US, else 0), MSB first.
    - If bit index < 39: increment index, go to BIT_LOW.
    - If bit index = 39: go to CHECK.
- Dwell counter: reset on every state entry. Reaching TIMEOUT_US in any wait state → timeout_err pulse, go to IDLE. tem/hum are unchanged.
- CHECK (one cycle): frame bytes b0..b4 = bits 39..0.
  - If (b0+b1+b2+b3) mod 256 == b4: tem<=b2, hum<=b0, data_valid=1 in the following cycle.
  - Else: cks_err=1, outputs hold.
  - Then go to IDLE and restart the poll count.
  - Decimal bytes b1/b3 are discarded.
- Sum arithmetic is 10-bit; compare the low 8 bits.
- enable dropping mid-transaction does not abort; the frame completes normally.
- reset mid-transaction releases the line immediately.
- data_valid, cks_err and timeout_err are mutually exclusive and each exactly 1 cycle.

Optional Feature:
- Macro: DHT_RETRY_EN.
- Defined:
  - After cks_err or timeout_err, IDLE waits 2 ms (not POLL_MS) before retrying, up to 3 consecutive retries; then falls back to POLL_MS.
  - The retry count clears on data_valid or reset.
- Undefined: every error returns to the full POLL_MS wait.

Test Plan:
- Good frame: CLK_HZ=1_000_000, POLL_MS=1. Sensor model replies hum=55,0 tem=24,0 cks=79 → line low 18000 us after poll; tem=24, hum=55, data_valid single pulse; busy low after.
- Bit threshold: frame with bits high 26 us (0) and 70 us (1) decodes to 0x37,0x00,0x18,0x00,0x4F. A 50 us high decodes as 0, a 51 us high as 1.
- Checksum error: same frame with cks=80 → cks_err pulse, tem/hum keep previous values (24/55), no data_valid.
- Timeout: sensor never acknowledges → timeout_err 200 us after release, line released, next start after POLL_MS. With DHT_RETRY_EN, next start comes after 2 ms, ×3, then POLL_MS.
- Reset mid-frame: assert reset during bit 20 → line Z the same cycle, tem=hum=0, FSM idle; recovery frame decodes correctly.
- enable=0: no start pulse for 5×POLL_MS. Deasserting enable during bit 10 still completes the frame with data_valid.
